// File: rtl/irq_controller.sv
// Interrupt controller: per-source synchronisers, edge/level capture into PENDING,
// masked lowest-index arbitration and an IDLE/ASSERT/HOLDOFF request handshake.
module irq_controller #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [N_SRC-1:0] src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_d,
  output logic [31:0]      cfg_q,
  output logic             irq,
  output logic [4:0]       irq_id,
  input  logic             ack
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 5;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] synced;
  logic [N_SRC-1:0] synced_prev;
  logic [N_SRC-1:0] evt;

  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mode;

  logic [N_SRC-1:0] req_vec;
  logic             req_any;
  logic [ID_W-1:0]  low_idx;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] wr_clr;
  logic [N_SRC-1:0] pending_n;

  logic             mask_we;
  logic             pend_we;
  logic             mode_we;
  logic [DATA_W-1:0] rd_data_c;

  state_t           state;
  state_t           state_n;
  logic [ID_W-1:0]  irq_id_n;

  // Upper write-data bits beyond N_SRC carry no state
  logic cfg_d_unused;
  assign cfg_d_unused = ^cfg_d;

  // Synchroniser chain; only the last stage is used downstream
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Capture event is registered, so PENDING lands one cycle after the synced transition
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      synced_prev <= '0;
      evt         <= '0;
    end else begin
      synced_prev <= synced;
      evt         <= (mode & synced) | (~mode & synced & ~synced_prev);
    end
  end

  assign mask_we = cfg_we && (cfg_addr == ADDR_MASK);
  assign pend_we = cfg_we && (cfg_addr == ADDR_PENDING);
  assign mode_we = cfg_we && (cfg_addr == ADDR_MODE);

  // Clear sources: acknowledge of the current request and write-1-to-clear
  always_comb begin
    ack_clr = '0;
    if ((state == ASSERT) && ack) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        ack_clr[i] = (irq_id == ID_W'(i));
      end
    end
  end

  assign wr_clr    = pend_we ? cfg_d[N_SRC-1:0] : '0;
  assign pending_n = (pending & ~(ack_clr | wr_clr)) | evt;

  // Configuration and pending registers; a new event always wins over a clear
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mask    <= '0;
      pending <= '0;
      mode    <= '0;
    end else begin
      pending <= pending_n;
      if (mask_we) begin
        mask <= cfg_d[N_SRC-1:0];
      end
      if (mode_we) begin
        mode <= cfg_d[N_SRC-1:0];
      end
    end
  end

  assign req_vec = pending & mask;
  assign req_any = |req_vec;

  // Lowest set index wins
  always_comb begin
    low_idx = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        low_idx = ID_W'(i);
      end
    end
  end

  // Request handshake: next state and next latched id
  always_comb begin
    state_n  = state;
    irq_id_n = irq_id;
    case (state)
      IDLE: begin
        if (req_any) begin
          state_n  = ASSERT;
          irq_id_n = low_idx;
        end
      end
      ASSERT: begin
        if (ack) begin
          state_n = HOLDOFF;
        end
      end
      HOLDOFF: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      state  <= state_n;
      irq    <= (state_n == ASSERT);
      irq_id <= irq_id_n;
    end
  end

  // Read mux; result registered onto cfg_q
  always_comb begin
    rd_data_c = '0;
    case (cfg_addr)
      ADDR_MASK:    rd_data_c = DATA_W'(mask);
      ADDR_PENDING: rd_data_c = DATA_W'(pending);
      ADDR_MODE:    rd_data_c = DATA_W'(mode);
      ADDR_STATUS:  rd_data_c = {23'd0, irq, 3'd0, irq_id};
      default:      rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= rd_data_c;
    end
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per source (legal 2..4).
REQ-003 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port: nreset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: src  input  N_SRC  raw interrupt sources, asynchronous to clk, active high.
REQ-006 SHALL have port: cfg_we  input  1  register write strobe.
REQ-007 SHALL have port: cfg_addr  input  2  register select: 0 MASK, 1 PENDING, 2 MODE, 3 STATUS.
REQ-008 SHALL have port: cfg_d  input  32  write data.
REQ-009 SHALL have port: cfg_q  output  32  registered read data.
REQ-010 SHALL have port: irq  output  1  interrupt request to CPU.
REQ-011 SHALL have port: irq_id  output  5  index of the source being requested.
REQ-012 SHALL have port: ack  input  1  one-cycle CPU acknowledge of the current request.

Function
REQ-013 SHALL pass each src bit through a SYNC_STAGES flip-flop chain; only the chain output (synced) SHALL be used internally.
REQ-014 SHALL, with MODE[i]=0 (edge), set PENDING[i] on the cycle after a 0->1 transition of synced[i].
REQ-015 SHALL, with MODE[i]=1 (level), set PENDING[i] on every cycle synced[i] is 1.
REQ-016 SHALL give latency: src[i] rising before clock edge 0 -> PENDING[i]=1 after edge SYNC_STAGES+1 -> irq=1 after edge SYNC_STAGES+2.
REQ-017 SHALL implement FSM states IDLE, ASSERT, HOLDOFF.
REQ-018 SHALL, in IDLE, when (PENDING & MASK) != 0, latch irq_id = lowest set index and go to ASSERT.
REQ-019 SHALL drive irq=1 only in ASSERT; irq_id is held stable throughout ASSERT.
REQ-020 SHALL, on ack=1 in ASSERT, clear PENDING[irq_id] and go to HOLDOFF; ack in IDLE or HOLDOFF is ignored.
REQ-021 SHALL leave HOLDOFF for IDLE after exactly one cycle, so irq is low for at least one cycle between requests.
REQ-022 SHALL keep irq asserted in ASSERT until ack, even if MASK or PENDING of irq_id is cleared meanwhile; no retraction.
REQ-023 SHALL give set priority over clear: a new event on source i in the same cycle as ack- or write-clear of PENDING[i] leaves PENDING[i]=1.
REQ-024 SHALL treat PENDING writes as write-1-to-clear; MASK and MODE writes as plain writes; STATUS writes are ignored.
REQ-025 SHALL return on cfg_q, one cycle after cfg_addr is presented: MASK, PENDING, MODE, or STATUS = {irq at bit 8, irq_id at bits 4:0}.
REQ-026 SHALL ignore cfg_d bits at N_SRC and above; those cfg_q bits and all unused STATUS bits SHALL read 0.
REQ-027 SHALL keep PENDING[i] masked-off sources recorded: a masked source sets PENDING but does not request until unmasked.

Reset
REQ-028 SHALL, while nreset=0, force: state IDLE, irq=0, irq_id=0, cfg_q=0, MASK=0, PENDING=0, MODE=0, all synchroniser flops 0.
REQ-029 SHALL, after reset release, treat a source held high through reset as a fresh rising edge, setting PENDING after SYNC_STAGES+1 cycles.
REQ-030 SHALL, on reset assertion mid-request (ASSERT), drop irq asynchronously and lose all pending state.

Verification
REQ-031 SHALL cover: MASK=0xFF, MODE=0, pulse src[3] for 1 cycle -> irq=1, irq_id=3 at edge SYNC_STAGES+2; ack -> PENDING=0x00, irq=0 next cycle.
REQ-032 SHALL cover: src[5] and src[2] rise same cycle, MASK=0xFF -> irq_id=2 first; ack; one cycle irq=0 (HOLDOFF); then irq_id=5.
REQ-033 SHALL cover: MASK=0x00, pulse src[1] -> PENDING=0x02, irq stays 0; write MASK=0x02 -> irq=1, irq_id=1 two cycles later.
REQ-034 SHALL cover: MODE[4]=1, src[4] held high, ack -> PENDING[4] re-sets and irq reasserts with irq_id=4 after HOLDOFF; release src[4], ack -> irq stays 0.
REQ-035 SHALL cover: rising edge on src[6] in the same cycle as W1C write of 0x40 to PENDING -> PENDING[6]=1.
REQ-036 SHALL cover: nreset pulsed low during ASSERT with irq_id=3 -> irq=0, PENDING=0, STATUS reads 0x000.
